// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: boolean
// literals, default geometry, fetch address span and FSM state codes.
package icache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;

  // Highest fetch address bit that takes part in tag/index/offset.
  localparam int ADDR_MSB = 17;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REFILL  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache with single-word refill handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | look up the request; a hit answers on the next cycle
// ST_REFILL  | fetch WORDS words of the missing line, one mem_valid each
// ST_RESPOND | read_ready high with the requested word from the refill
module icache
  import icache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] addr,
  input  logic        rn,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        read_ready,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data,
  input  logic        mem_valid
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int IDX_LSB = OFF_W + 2;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_MSB + 1 - TAG_LSB;
  localparam int BASE_W  = ADDR_MSB + 1 - IDX_LSB;
  localparam logic [OFF_W-1:0] K_LAST = OFF_W'(WORDS - 1);

  word_t                  data_mem [LINES*WORDS];
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [LINES-1:0]       valid;

  logic [1:0]             state;
  logic [OFF_W-1:0]       k;
  logic [OFF_W-1:0]       off_q;
  logic [BASE_W-1:0]      base;
  logic                   flushed;
  word_t                  resp_word;

  logic [OFF_W-1:0]       req_off;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       line_idx;
  logic                   hit;
  logic                   unused_addr;

  assign req_off  = addr[IDX_LSB-1:2];
  assign req_idx  = addr[TAG_LSB-1:IDX_LSB];
  assign req_tag  = addr[ADDR_MSB:TAG_LSB];
  assign line_idx = base[IDX_W-1:0];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // Bits above the cacheable span and the byte lane are don't-care.
  assign unused_addr = ^{addr[31:ADDR_MSB+1], addr[1:0]};

  // base and k reset to zero, so the refill address reads 0 during reset.
  assign mem_req  = (state == ST_REFILL);
  assign mem_addr = {{(31 - ADDR_MSB){1'b0}}, base, k, 2'b00};

  // Control FSM, valid bits and response registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      k          <= '0;
      off_q      <= '0;
      base       <= '0;
      flushed    <= FALSE;
      valid      <= '0;
      read_ready <= FALSE;
      inst       <= '0;
      resp_word  <= '0;
    end else if (rdy) begin
      read_ready <= FALSE;
      if (flush) valid <= '0;
      case (state)
        ST_IDLE: begin
          // A flush in the same cycle forces the request down the miss path.
          if (rn && !read_ready) begin
            if (hit && !flush) begin
              inst       <= data_mem[{req_idx, req_off}];
              read_ready <= TRUE;
            end else begin
              base    <= addr[ADDR_MSB:IDX_LSB];
              off_q   <= req_off;
              k       <= '0;
              flushed <= FALSE;
              state   <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (flush) flushed <= TRUE;
          if (mem_valid) begin
            k <= k + 1'b1;
            if (k == off_q) resp_word <= mem_data;
            if (k == K_LAST) begin
              // A flush seen anywhere during this refill leaves the line invalid.
              if (!flush && !flushed) valid[line_idx] <= TRUE;
              inst       <= (k == off_q) ? mem_data : resp_word;
              read_ready <= TRUE;
              state      <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Data and tag arrays are written only by the refill and need no reset.
  always_ff @(posedge clk) begin
    if (rdy && (state == ST_REFILL) && mem_valid) begin
      data_mem[{line_idx, k}] <= mem_data;
      if (k == K_LAST) tag_mem[line_idx] <= base[BASE_W-1:IDX_W];
    end
  end

endmodule
